// File: rtl/mo_line_scanner_if.sv
// Scanner bus: registered-read MO RAM port plus the valid/ready object record stream.
// master = scanner side, slave = RAM model / line-buffer writer side.
interface mo_line_scanner_if;
  logic [7:0] ram_a;
  logic       ram_r;
  logic [7:0] ram_d;
  logic       obj_valid;
  logic       obj_ready;
  logic [7:0] obj_code;
  logic [7:0] obj_attr;
  logic [7:0] obj_x;
  logic [3:0] obj_row;

  modport master (
    output ram_a, ram_r, obj_valid, obj_code, obj_attr, obj_x, obj_row,
    input  ram_d, obj_ready
  );

  modport slave (
    input  ram_a, ram_r, obj_valid, obj_code, obj_attr, obj_x, obj_row,
    output ram_d, obj_ready
  );
endinterface

// File: rtl/mo_line_scanner.sv
// Per-hblank MO slot scan into a small record FIFO: 2 cycles per hidden slot, 6 per visible one.
// Holds in PUSH while the FIFO is full; MO_VFLIP_EN makes attr[7] flip the output row.
module mo_line_scanner #(
  parameter int NUM_OBJ      = 64,
  parameter int OBJ_H        = 16,
  parameter int MAX_PER_LINE = 8,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] line,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  mo_line_scanner_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD_Y, CHK, RD_CODE, RD_ATTR, RD_X, PUSH, DONE} state_t;

  typedef struct packed {
    logic [7:0] code;
    logic [7:0] attr;
    logic [7:0] x;
    logic [3:0] row;
  } obj_rec_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [5:0]    LAST_SLOT = 6'(NUM_OBJ - 1);
  localparam logic [7:0]    OBJ_H8    = 8'(OBJ_H);
  localparam logic [7:0]    MAX_CNT   = 8'(MAX_PER_LINE);

  state_t     state;
  logic [7:0] line_q;
  logic [5:0] slot;
  logic [3:0] diff_q;
  logic [7:0] code_q, attr_q, x_q;
  logic       push_first;
  logic [7:0] acc_cnt;

  obj_rec_t      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;

  logic [7:0] diff;
  logic       visible, last_slot, abort, fifo_full, push, pop;
  logic [7:0] x_now;
  logic [3:0] row_now;
  obj_rec_t   push_rec, head;

  // Modulo-256 distance makes objects straddling the top of the frame visible.
  assign diff      = line_q - bus.ram_d;
  assign visible   = diff < OBJ_H8;
  assign last_slot = (slot == LAST_SLOT);
  assign abort     = start && busy;
  assign fifo_full = (cnt == FULL_CNT);
  assign push      = (state == PUSH) && !fifo_full && !start;
  assign pop       = bus.obj_valid && bus.obj_ready;

  // X arrives on the first PUSH cycle; a stalled PUSH uses the held copy.
  assign x_now = push_first ? bus.ram_d : x_q;

`ifdef MO_VFLIP_EN
  localparam logic [3:0] ROW_MASK = 4'(OBJ_H - 1);
  assign row_now = attr_q[7] ? (~diff_q & ROW_MASK) : diff_q;
`else
  assign row_now = diff_q;
`endif

  assign push_rec = {code_q, attr_q, x_now, row_now};

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bus.ram_a  <= 8'h00;
      bus.ram_r  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
      line_q     <= 8'h00;
      slot       <= 6'd0;
      diff_q     <= 4'h0;
      code_q     <= 8'h00;
      attr_q     <= 8'h00;
      x_q        <= 8'h00;
      push_first <= 1'b0;
      acc_cnt    <= 8'h00;
    end else begin
      done      <= 1'b0;
      bus.ram_r <= 1'b0;
      if (start) begin
        line_q    <= line;
        slot      <= 6'd0;
        acc_cnt   <= 8'h00;
        overflow  <= 1'b0;
        busy      <= 1'b1;
        bus.ram_r <= 1'b1;
        bus.ram_a <= 8'h00;
        state     <= RD_Y;
      end else begin
        case (state)
          IDLE: ;
          RD_Y: state <= CHK;
          CHK: begin
            diff_q <= diff[3:0];
            if (visible && acc_cnt == MAX_CNT) begin
              overflow <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else if (visible) begin
              acc_cnt   <= acc_cnt + 8'd1;
              bus.ram_r <= 1'b1;
              bus.ram_a <= {slot, 2'd1};
              state     <= RD_CODE;
            end else if (last_slot) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              slot      <= slot + 6'd1;
              bus.ram_r <= 1'b1;
              bus.ram_a <= {slot + 6'd1, 2'd0};
              state     <= RD_Y;
            end
          end
          RD_CODE: begin
            bus.ram_r <= 1'b1;
            bus.ram_a <= {slot, 2'd2};
            state     <= RD_ATTR;
          end
          RD_ATTR: begin
            code_q    <= bus.ram_d;
            bus.ram_r <= 1'b1;
            bus.ram_a <= {slot, 2'd3};
            state     <= RD_X;
          end
          RD_X: begin
            attr_q     <= bus.ram_d;
            push_first <= 1'b1;
            state      <= PUSH;
          end
          PUSH: begin
            push_first <= 1'b0;
            if (push_first) x_q <= bus.ram_d;
            if (!fifo_full) begin
              if (last_slot) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= DONE;
              end else begin
                slot      <= slot + 6'd1;
                bus.ram_r <= 1'b1;
                bus.ram_a <= {slot + 6'd1, 2'd0};
                state     <= RD_Y;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_rec;
  end

  assign head          = fifo_mem[rd_ptr];
  assign bus.obj_valid = (cnt != '0);
  assign bus.obj_code  = bus.obj_valid ? head.code : 8'h00;
  assign bus.obj_attr  = bus.obj_valid ? head.attr : 8'h00;
  assign bus.obj_x     = bus.obj_valid ? head.x    : 8'h00;
  assign bus.obj_row   = bus.obj_valid ? head.row  : 4'h0;

endmodule
